uart_serial_engine: RTL and testbench

//  Bit-level 8N1 UART transmitter/receiver. Serialises bytes handed down by the

---
 rtl/uart_serial_engine.sv | 218 +++++++++++++++++++++
 tb/tb_uart_serial_engine.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_serial_engine.sv
// Bit-level 8N1 UART engine: independent TX serialiser and RX deserialiser,
// each driven by its own 16-bit down counter.
module uart_serial_engine #(
  parameter int unsigned DIVISOR = 217
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic       tx_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_frame_err_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_start_i,
  output logic       tx_busy_o,
  output logic       tx_done_o
);

  // Reload values are one less than the interval because the counter
  // expires on 0, so a bit spans exactly DIVISOR cycles.
  localparam logic [15:0] BIT_RELOAD  = 16'(DIVISOR - 1);
  localparam logic [15:0] HALF_RELOAD = 16'((DIVISOR / 2) - 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // ---------------------------------------------------------------------
  // RX input synchroniser and edge history
  // ---------------------------------------------------------------------
  logic rx_meta;
  logic rx_s;
  logic rx_s_d;

  // NOTE: synchroniser flops preset to 1 (idle line) so leaving reset never
  // looks like a falling start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  // ---------------------------------------------------------------------
  // RX FSM
  // ---------------------------------------------------------------------
  rx_state_t   rx_state;
  rx_state_t   rx_next;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_idx;
  logic [7:0]  rx_shift;
  logic        rx_tick;

  assign rx_tick = (rx_cnt == 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      RX_IDLE:      if (rx_s_d && !rx_s) rx_next = RX_START;
      RX_START:     if (rx_tick) rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:      if (rx_tick && rx_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:      if (rx_tick) rx_next = rx_s ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (rx_s) rx_next = RX_IDLE;
      default:      rx_next = RX_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt         <= 16'd0;
      rx_idx         <= 3'd0;
      rx_shift       <= 8'd0;
      rx_data_o      <= 8'd0;
      rx_valid_o     <= 1'b0;
      rx_frame_err_o <= 1'b0;
    end else begin
      rx_valid_o     <= 1'b0;
      rx_frame_err_o <= 1'b0;
      unique case (rx_state)
        RX_IDLE: begin
          rx_cnt <= HALF_RELOAD;
          rx_idx <= 3'd0;
        end
        RX_START: begin
          rx_cnt <= rx_tick ? BIT_RELOAD : rx_cnt - 16'd1;
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_idx   <= rx_idx + 3'd1;
            rx_cnt   <= BIT_RELOAD;
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_tick) begin
            if (rx_s) begin
              rx_data_o  <= rx_shift;
              rx_valid_o <= 1'b1;
            end else begin
              rx_frame_err_o <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // TX FSM
  // ---------------------------------------------------------------------
  tx_state_t   tx_state;
  tx_state_t   tx_next;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_idx;
  logic [7:0]  tx_shift;
  logic        tx_tick;

  assign tx_tick   = (tx_cnt == 16'd0);
  assign tx_busy_o = (tx_state != TX_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    unique case (tx_state)
      TX_IDLE:  if (tx_start_i) tx_next = TX_START;
      TX_START: if (tx_tick) tx_next = TX_DATA;
      TX_DATA:  if (tx_tick && tx_idx == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_tick) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // tx_o is registered with an async preset so the pad returns high the
  // instant reset asserts, with no combinational glitch path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_o      <= 1'b1;
      tx_cnt    <= 16'd0;
      tx_idx    <= 3'd0;
      tx_shift  <= 8'd0;
      tx_done_o <= 1'b0;
    end else begin
      tx_done_o <= 1'b0;
      unique case (tx_state)
        TX_IDLE: begin
          if (tx_start_i) begin
            tx_shift <= tx_data_i;
            tx_cnt   <= BIT_RELOAD;
            tx_o     <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_tick) begin
            tx_o   <= tx_shift[0];
            tx_idx <= 3'd0;
            tx_cnt <= BIT_RELOAD;
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_tick) begin
            tx_cnt <= BIT_RELOAD;
            tx_idx <= tx_idx + 3'd1;
            if (tx_idx == 3'd7) begin
              tx_o <= 1'b1;
            end else begin
              tx_o     <= tx_shift[1];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_tick) tx_done_o <= 1'b1;
          else         tx_cnt    <= tx_cnt - 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_serial_engine.sv
// Self-checking bench for uart_serial_engine (DIVISOR=4): directed TX waveform
// check plus an RX byte scoreboard fed by bench-driven frames and loopback.
module tb_uart_serial_engine;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_i;
  logic       tx_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_frame_err_o;
  logic [7:0] tx_data_i;
  logic       tx_start_i;
  logic       tx_busy_o;
  logic       tx_done_o;

  logic       loopback;
  logic       rx_drv;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_ferr   = 0;
  int n_done   = 0;

  logic [7:0] rx_q[$];
  logic [9:0] frame;

  assign rx_i = loopback ? tx_o : rx_drv;

  always #5 clk = ~clk;

  uart_serial_engine #(.DIVISOR(DIV)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_i           (rx_i),
    .tx_o           (tx_o),
    .rx_data_o      (rx_data_o),
    .rx_valid_o     (rx_valid_o),
    .rx_frame_err_o (rx_frame_err_o),
    .tx_data_i      (tx_data_i),
    .tx_start_i     (tx_start_i),
    .tx_busy_o      (tx_busy_o),
    .tx_done_o      (tx_done_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // RX scoreboard and strobe counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_valid_o && rx_frame_err_o) check("rx_valid_and_err", 1, 0);
    if (rx_valid_o) begin
      n_valid++;
      if (rx_q.size() == 0) check("rx_unexpected_byte", {24'd0, rx_data_o}, 32'hFFFF_FFFF);
      else                  check("rx_data", {24'd0, rx_data_o}, {24'd0, rx_q.pop_front()});
    end
    if (rx_frame_err_o) n_ferr++;
    if (tx_done_o)      n_done++;
  end

  task automatic tx_send(input logic [7:0] b);
    tx_data_i  = b;
    tx_start_i = 1'b1;
    @(negedge clk);
    tx_start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (tx_done_o) seen = 1'b1;
    end
    check(tag, {31'd0, seen}, 1);
  endtask

  task automatic send_rx_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      repeat (DIV) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, d0, e0;
    rst_n      = 1'b0;
    loopback   = 1'b0;
    rx_drv     = 1'b1;
    tx_data_i  = 8'h00;
    tx_start_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_o",      tx_o,           1);
    check("rst_tx_busy",   tx_busy_o,      0);
    check("rst_tx_done",   tx_done_o,      0);
    check("rst_rx_data",   rx_data_o,      0);
    check("rst_rx_valid",  rx_valid_o,     0);
    check("rst_rx_ferr",   rx_frame_err_o, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: exact TX waveform for 0xA5, data input changed mid-frame
    check("tx_idle_busy", tx_busy_o, 0);
    frame      = {1'b1, 8'hA5, 1'b0};
    tx_data_i  = 8'hA5;
    tx_start_i = 1'b1;
    for (int k = 1; k <= 10 * DIV; k++) begin
      @(negedge clk);
      if (k == 1) begin
        tx_start_i = 1'b0;
        tx_data_i  = 8'hFF;
        check("tx_busy_first", tx_busy_o, 1);
      end
      check("tx_bit", tx_o, frame[(k - 1) / DIV]);
      if (k == 10 * DIV) begin
        check("tx_busy_last", tx_busy_o, 1);
        check("tx_done_early", tx_done_o, 0);
      end
    end
    @(negedge clk);
    check("tx_done_at_40", tx_done_o, 1);
    check("tx_busy_clear", tx_busy_o, 0);
    @(negedge clk);
    check("tx_done_one_cycle", tx_done_o, 0);
    check("tx_idle_high", tx_o, 1);

    // 2: loopback, back-to-back frames issued on tx_done_o
    loopback = 1'b1;
    repeat (5) @(negedge clk);
    v0 = n_valid; e0 = n_ferr;
    rx_q.push_back(8'h00);
    rx_q.push_back(8'hFF);
    rx_q.push_back(8'h3C);
    tx_send(8'h00);
    wait_done("b2b_done0");
    tx_send(8'hFF);
    check("b2b_no_gap_busy", tx_busy_o, 1);
    check("b2b_no_gap_start", tx_o, 0);
    wait_done("b2b_done1");
    tx_send(8'h3C);
    wait_done("b2b_done2");
    repeat (10) @(negedge clk);
    check("b2b_rx_count", n_valid - v0, 3);
    check("b2b_no_ferr", n_ferr - e0, 0);
    check("b2b_queue_empty", rx_q.size(), 0);

    // 3: one-cycle glitch is rejected; a real frame right after is received
    loopback = 1'b0;
    rx_drv   = 1'b1;
    repeat (5) @(negedge clk);
    v0 = n_valid; e0 = n_ferr;
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_no_valid", n_valid - v0, 0);
    check("glitch_no_ferr", n_ferr - e0, 0);
    rx_q.push_back(8'h5A);
    send_rx_frame(8'h5A, 1'b1);
    repeat (8) @(negedge clk);
    check("after_glitch_rx", n_valid - v0, 1);

    // 4: framing error, line held low, then recovery
    v0 = n_valid; e0 = n_ferr;
    send_rx_frame(8'h55, 1'b0);
    rx_drv = 1'b0;
    repeat (50) @(negedge clk);
    rx_drv = 1'b1;
    check("ferr_count", n_ferr - e0, 1);
    check("ferr_no_valid", n_valid - v0, 0);
    check("ferr_data_kept", rx_data_o, 8'h5A);
    repeat (10) @(negedge clk);
    rx_q.push_back(8'h12);
    send_rx_frame(8'h12, 1'b1);
    repeat (8) @(negedge clk);
    check("recover_rx", n_valid - v0, 1);
    check("recover_no_ferr", n_ferr - e0, 1);

    // 5: start requests while busy are ignored
    loopback = 1'b1;
    repeat (5) @(negedge clk);
    v0 = n_valid; d0 = n_done;
    rx_q.push_back(8'hC3);
    tx_send(8'hC3);
    for (int i = 0; i < 8; i++) begin
      tx_data_i  = 8'h99;
      tx_start_i = 1'b1;
      @(negedge clk);
      tx_start_i = 1'b0;
      repeat (2) @(negedge clk);
    end
    wait_done("busy_done");
    repeat (20) @(negedge clk);
    check("busy_one_done", n_done - d0, 1);
    check("busy_one_byte", n_valid - v0, 1);
    check("busy_idle_after", tx_busy_o, 0);

    // 6: asynchronous reset mid-frame on both paths
    tx_send(8'hF0);
    repeat (13) @(negedge clk);
    check("mid_tx_low", tx_o, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_tx_o", tx_o, 1);
    check("async_tx_busy", tx_busy_o, 0);
    check("async_tx_done", tx_done_o, 0);
    check("async_rx_data", rx_data_o, 0);
    check("async_rx_valid", rx_valid_o, 0);
    check("async_rx_ferr", rx_frame_err_o, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    v0 = n_valid; e0 = n_ferr;
    rx_q.push_back(8'h81);
    tx_send(8'h81);
    wait_done("post_rst_done");
    repeat (10) @(negedge clk);
    check("post_rst_rx", n_valid - v0, 1);
    check("post_rst_no_ferr", n_ferr - e0, 0);
    check("post_rst_rx_data", rx_data_o, 8'h81);

    check("final_queue_empty", rx_q.size(), 0);
    check("total_valid", n_valid, 7);
    check("total_ferr", n_ferr, 1);
    check("total_done", n_done, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
